// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle IF/ID/EX/MEM/WB sequencer that owns the program
// counter, paces fetch and data accesses through explicit memory handshakes and
// produces the IR, register-file and PC write strobes.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             is_jmp,
    input  logic [31:0]      jmp_pc,
    input  logic             is_mem,
    input  logic             is_store,
    input  logic             halt,
    output logic [31:0]      pc_o,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             reg_we,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             err
);

    // Wait counter only has to count 0..TIMEOUT-1.
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t            state;
    logic              jmp_q;
    logic              st_q;
    logic [31:0]       tgt_q;
    logic [WAIT_W-1:0] wait_cnt;

    // Strobes are decoded from the current state and the memory acks.
    always_comb begin
        imem_req = (state == S_IF);
        ir_we    = imem_req & imem_ack;
        dmem_req = (state == S_MEM);
        reg_we   = (state == S_WB) & ~st_q & ~jmp_q;
    end

    assign state_o = state;

    // Sequencer FSM: state, PC, retired counter, EX-stage latches and timeout.
    // The wait counter holds the number of ack-less cycles already spent in the
    // current IF/MEM visit, so the TIMEOUT-th miss is detected when it equals
    // TIMEOUT-1; an ack in that same cycle takes priority over the error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IF;
            pc_o        <= RESET_PC;
            retired_cnt <= '0;
            err         <= 1'b0;
            jmp_q       <= 1'b0;
            st_q        <= 1'b0;
            tgt_q       <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IF: begin
                    if (imem_ack) begin
                        state    <= S_ID;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_ID: begin
                    state <= S_EX;
                end
                S_EX: begin
                    jmp_q <= is_jmp;
                    tgt_q <= jmp_pc & 32'hFFFF_FFFC;
                    st_q  <= is_mem & is_store;
                    if (is_mem) begin
                        state    <= S_MEM;
                        wait_cnt <= '0;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        state    <= S_WB;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    pc_o        <= jmp_q ? tgt_q : pc_o + 32'd4;
                    retired_cnt <= retired_cnt + CNT_W'(1);
                    wait_cnt    <= '0;
                    state       <= halt ? S_HALT : S_IF;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    err   <= 1'b1;
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule
